// File: rtl/write_ptr_handler.sv
// Write-domain side of an asynchronous FIFO: binary/Gray write pointer, two-flop
// read-pointer synchronizer, and registered Full/AlmostFull/WriteLevel/Overflow.
module write_ptr_handler #(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  write_clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH:0]   ReadAddr_gray,
    output logic                  write_accept,
    output logic [ADDR_WIDTH-1:0] WriteAddr_bin,
    output logic [ADDR_WIDTH:0]   WriteAddr,
    output logic [ADDR_WIDTH:0]   sync_ReadAddr,
    output logic                  Full,
    output logic                  AlmostFull,
    output logic [ADDR_WIDTH:0]   WriteLevel,
    output logic                  Overflow
);

    localparam int              PW        = ADDR_WIDTH + 1;
    localparam int              DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0]   AF_THRESH = PW'(DEPTH - AF_MARGIN);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic [PW-1:0] r_sync1;
    logic [PW-1:0] r_sync_rd;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic          w_write_accept;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_full_gray;
    logic [PW-1:0] w_level_next;

    // Next-state pointer, level and full-compare values
    always_comb begin
        w_write_accept = write_en & ~r_full;
        w_wbin_next    = r_wbin + {{ADDR_WIDTH{1'b0}}, w_write_accept};
        w_wgray_next   = bin2gray(w_wbin_next);
        w_rbin         = gray2bin(r_sync_rd);
        // Full when write pointer is one lap ahead: top two Gray bits inverted
        w_full_gray    = {~r_sync_rd[ADDR_WIDTH:ADDR_WIDTH-1], r_sync_rd[ADDR_WIDTH-2:0]};
        w_level_next   = w_wbin_next - w_rbin;
    end

    // Pointer, synchronizer and flag registers
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin        <= {PW{1'b0}};
            r_wgray       <= {PW{1'b0}};
            r_sync1       <= {PW{1'b0}};
            r_sync_rd     <= {PW{1'b0}};
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= {PW{1'b0}};
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_sync1       <= ReadAddr_gray;
            r_sync_rd     <= r_sync1;
            r_full        <= (w_wgray_next == w_full_gray);
            r_almost_full <= (w_level_next >= AF_THRESH);
            r_level       <= w_level_next;
            r_overflow    <= write_en & r_full;
        end
    end

    assign write_accept  = w_write_accept;
    assign WriteAddr_bin = r_wbin[ADDR_WIDTH-1:0];
    assign WriteAddr     = r_wgray;
    assign sync_ReadAddr = r_sync_rd;
    assign Full          = r_full;
    assign AlmostFull    = r_almost_full;
    assign WriteLevel    = r_level;
    assign Overflow      = r_overflow;

endmodule
